// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline hazard controller.
//   ctrl_state_t : controller FSM state (RUN / MEM_WAIT)
//   REG_IDX_W    : architectural register index width
//   PC_REG       : register index of the PC, never treated as a hazard source
package pipe_ctrl_pkg;
    localparam int REG_IDX_W = 4;
    localparam logic [REG_IDX_W-1:0] PC_REG = 4'd15;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } ctrl_state_t;
endpackage

// File: rtl/pipe_hazard_detect.sv
// pipe_hazard_detect: combinational RAW hazard compare for the instruction in ID.
// Build option: PIPE_FORWARDING_EN -- when defined, a forwarding unit covers
// everything except load-use, so only a load in EXE can cause a stall.
// Ports:
//   id_src1/id_src2/id_two_src/id_valid : sources read by the ID instruction
//   exe_dest/exe_wb_en/exe_mem_r_en     : producer in EXE
//   mem_dest/mem_wb_en                  : producer in MEM
//   hazard                              : ID must stall
module pipe_hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_IDX_W-1:0] id_src1,
    input  logic [REG_IDX_W-1:0] id_src2,
    input  logic                 id_two_src,
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] exe_dest,
    input  logic                 exe_wb_en,
    input  logic                 exe_mem_r_en,
    input  logic [REG_IDX_W-1:0] mem_dest,
    input  logic                 mem_wb_en,
    output logic                 hazard
);
    logic exe_hit;

    // PC writes are handled by the branch path, so dest 15 never stalls.
    assign exe_hit = exe_wb_en && (exe_dest != PC_REG) &&
                     ((id_src1 == exe_dest) || (id_two_src && (id_src2 == exe_dest)));

`ifdef PIPE_FORWARDING_EN
    logic unused_mem;
    assign unused_mem = ^{mem_dest, mem_wb_en};
    assign hazard     = id_valid && exe_hit && exe_mem_r_en;
`else
    logic mem_hit;
    logic unused_ld;
    assign unused_ld = exe_mem_r_en;
    assign mem_hit   = mem_wb_en && (mem_dest != PC_REG) &&
                       ((id_src1 == mem_dest) || (id_two_src && (id_src2 == mem_dest)));
    assign hazard    = id_valid && (exe_hit || mem_hit);
`endif
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: freeze/bubble/flush sequencing of the IF/ID, ID/EX,
// EX/MEM and MEM/WB pipeline registers, with saturating statistics.
// Build option: PIPE_FORWARDING_EN (consumed by pipe_hazard_detect).
// Ports:
//   clk, rst (sync, active low)
//   id_*, exe_*, mem_dest/mem_wb_en : hazard compare inputs
//   mem_req/mem_ready               : data-memory handshake
//   br_taken                        : taken branch resolved in EXE
//   freeze_pc/freeze_pipe/bubble_idex/flush_ifid : combinational controls
//   mem_err                         : sticky memory timeout flag
//   stall_cnt/flush_cnt             : saturating statistics
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] id_src1,
    input  logic [REG_IDX_W-1:0] id_src2,
    input  logic                 id_two_src,
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] exe_dest,
    input  logic                 exe_wb_en,
    input  logic                 exe_mem_r_en,
    input  logic [REG_IDX_W-1:0] mem_dest,
    input  logic                 mem_wb_en,
    input  logic                 mem_req,
    input  logic                 mem_ready,
    input  logic                 br_taken,
    output logic                 freeze_pc,
    output logic                 freeze_pipe,
    output logic                 bubble_idex,
    output logic                 flush_ifid,
    output logic                 mem_err,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);
    localparam int WCW = $clog2(MEM_TIMEOUT + 1);

    ctrl_state_t    state;
    logic [WCW-1:0] wait_cnt;
    logic           hazard;
    logic           mem_wait;

    pipe_hazard_detect u_detect (
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_two_src   (id_two_src),
        .id_valid     (id_valid),
        .exe_dest     (exe_dest),
        .exe_wb_en    (exe_wb_en),
        .exe_mem_r_en (exe_mem_r_en),
        .mem_dest     (mem_dest),
        .mem_wb_en    (mem_wb_en),
        .hazard       (hazard)
    );

    // The request cycle that misses already freezes, so nothing advances
    // past a stalled MEM stage.
    assign mem_wait = (state == MEM_WAIT) || (mem_req && !mem_ready);

    // Priority: memory wait > branch flush > hazard stall. A branch held in
    // frozen EXE flushes on the first RUN cycle after the wait releases.
    always_comb begin
        freeze_pipe = mem_wait;
        freeze_pc   = 1'b0;
        bubble_idex = 1'b0;
        flush_ifid  = 1'b0;
        if (mem_wait) begin
            freeze_pc = 1'b1;
        end else if (br_taken) begin
            flush_ifid  = 1'b1;
            bubble_idex = 1'b1;
        end else if (hazard) begin
            freeze_pc   = 1'b1;
            bubble_idex = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= RUN;
            wait_cnt  <= '0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (freeze_pc && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_ifid && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);

            case (state)
                RUN: begin
                    if (mem_req && !mem_ready) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else begin
                        // Counter parks at the limit; the error is sticky and
                        // the FSM keeps waiting for the memory.
                        if (wait_cnt != WCW'(MEM_TIMEOUT))
                            wait_cnt <= wait_cnt + WCW'(1);
                        if (wait_cnt >= WCW'(MEM_TIMEOUT - 1))
                            mem_err <= 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;
    localparam int CNT_W       = 4;
    localparam int MEM_TIMEOUT = 4;
    localparam int CMAX        = (1 << CNT_W) - 1;

    typedef struct {
        bit       rst;
        bit [3:0] id_src1, id_src2, exe_dest, mem_dest;
        bit       id_two_src, id_valid, exe_wb_en, exe_mem_r_en, mem_wb_en;
        bit       mem_req, mem_ready, br_taken;
    } stim_t;

    typedef struct {
        bit fpc, fpipe, bub, fl, err;
        int sc, fc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic [3:0] id_src1, id_src2, exe_dest, mem_dest;
    logic id_two_src, id_valid, exe_wb_en, exe_mem_r_en, mem_wb_en;
    logic mem_req, mem_ready, br_taken;
    logic freeze_pc, freeze_pipe, bubble_idex, flush_ifid, mem_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src), .id_valid(id_valid),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
        .mem_req(mem_req), .mem_ready(mem_ready), .br_taken(br_taken),
        .freeze_pc(freeze_pc), .freeze_pipe(freeze_pipe), .bubble_idex(bubble_idex),
        .flush_ifid(flush_ifid), .mem_err(mem_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // Reference model state
    bit m_waiting = 1'b0;
    int m_wcycles = 0;
    bit m_err     = 1'b0;
    int m_stall   = 0;
    int m_flush   = 0;

    exp_t exp_q[$];
    int vectors     = 0;
    int miscompares = 0;

    function automatic bit ref_hazard(stim_t s);
        int srcs[$];
        int prod[$];
        if (!s.id_valid) return 1'b0;
        srcs.push_back(int'(s.id_src1));
        if (s.id_two_src) srcs.push_back(int'(s.id_src2));
`ifdef PIPE_FORWARDING_EN
        if (s.exe_wb_en && s.exe_mem_r_en) prod.push_back(int'(s.exe_dest));
`else
        if (s.exe_wb_en) prod.push_back(int'(s.exe_dest));
        if (s.mem_wb_en) prod.push_back(int'(s.mem_dest));
`endif
        foreach (srcs[i])
            foreach (prod[j])
                if (srcs[i] == prod[j] && prod[j] != 15) return 1'b1;
        return 1'b0;
    endfunction

    function automatic exp_t expect_out(stim_t s);
        exp_t e;
        bit mw = m_waiting || (s.mem_req && !s.mem_ready);
        bit hz = ref_hazard(s);
        e.fpipe = mw;
        e.fpc   = mw || (!s.br_taken && hz);
        e.fl    = !mw && s.br_taken;
        e.bub   = !mw && (s.br_taken || hz);
        e.err   = m_err;
        e.sc    = m_stall;
        e.fc    = m_flush;
        return e;
    endfunction

    task automatic model_step(stim_t s, exp_t e);
        if (!s.rst) begin
            m_waiting = 0; m_wcycles = 0; m_err = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (e.fpc) m_stall = (m_stall >= CMAX) ? CMAX : m_stall + 1;
            if (e.fl)  m_flush = (m_flush >= CMAX) ? CMAX : m_flush + 1;
            if (!m_waiting) begin
                if (s.mem_req && !s.mem_ready) begin m_waiting = 1; m_wcycles = 0; end
            end else if (s.mem_ready) begin
                m_waiting = 0; m_wcycles = 0;
            end else begin
                m_wcycles++;
                if (m_wcycles >= MEM_TIMEOUT) m_err = 1;
            end
        end
    endtask

    task automatic apply(input stim_t s, input bit chk);
        exp_t e;
        @(posedge clk);
        #1;
        rst = s.rst; id_src1 = s.id_src1; id_src2 = s.id_src2; id_two_src = s.id_two_src;
        id_valid = s.id_valid; exe_dest = s.exe_dest; exe_wb_en = s.exe_wb_en;
        exe_mem_r_en = s.exe_mem_r_en; mem_dest = s.mem_dest; mem_wb_en = s.mem_wb_en;
        mem_req = s.mem_req; mem_ready = s.mem_ready; br_taken = s.br_taken;
        e = expect_out(s);
        if (chk) exp_q.push_back(e);
        model_step(s, e);
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: 0};
        s.rst = 1'b1;
        return s;
    endfunction

    function automatic bit [3:0] pick_reg();
        case ($urandom_range(0, 3))
            0: return 4'd3;
            1: return 4'd5;
            2: return 4'd15;
            default: return 4'($urandom_range(0, 15));
        endcase
    endfunction

    // Monitor: compares every presented cycle against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (freeze_pc !== e.fpc || freeze_pipe !== e.fpipe || bubble_idex !== e.bub ||
                    flush_ifid !== e.fl || mem_err !== e.err ||
                    stall_cnt !== CNT_W'(e.sc) || flush_cnt !== CNT_W'(e.fc)) begin
                    miscompares++;
                    $display("FAIL outputs vec %0d t=%0t: got fpc=%b fpipe=%b bub=%b fl=%b err=%b sc=%0d fc=%0d, want fpc=%b fpipe=%b bub=%b fl=%b err=%b sc=%0d fc=%0d",
                             vectors, $time, freeze_pc, freeze_pipe, bubble_idex, flush_ifid, mem_err,
                             stall_cnt, flush_cnt, e.fpc, e.fpipe, e.bub, e.fl, e.err, e.sc, e.fc);
                end
            end
        end
    end

    initial begin
        stim_t s;
        s = idle(); s.rst = 0;
        apply(s, 0);
        apply(s, 0);
        s = idle();
        apply(s, 1);                       // reset state

        // EXE RAW hazard on src1
        s = idle(); s.id_valid = 1; s.id_src1 = 3; s.exe_dest = 3; s.exe_wb_en = 1;
        repeat (3) apply(s, 1);
        s.exe_mem_r_en = 1; apply(s, 1);
        s.exe_wb_en = 0; s.mem_dest = 3; s.mem_wb_en = 1; apply(s, 1);
        s.mem_dest = 15; s.id_src1 = 15; apply(s, 1);

        // memory wait, ready low 3 cycles
        s = idle(); s.mem_req = 1; apply(s, 1);
        s.mem_req = 0; repeat (2) apply(s, 1);
        s.mem_ready = 1; apply(s, 1);
        s = idle(); apply(s, 1);

        // branch with EXE hazard on src2
        s = idle(); s.id_valid = 1; s.id_two_src = 1; s.id_src1 = 1; s.id_src2 = 7;
        s.exe_dest = 7; s.exe_wb_en = 1; s.br_taken = 1; apply(s, 1);
        s = idle(); apply(s, 1);

        // branch during memory wait
        s = idle(); s.mem_req = 1; apply(s, 1);
        s.mem_req = 0; s.br_taken = 1; repeat (3) apply(s, 1);
        s.mem_ready = 1; apply(s, 1);
        s.mem_ready = 0; apply(s, 1);
        s.br_taken = 0; apply(s, 1);

        // timeout, sticky error
        s = idle(); s.mem_req = 1; apply(s, 1);
        s.mem_req = 0; repeat (6) apply(s, 1);
        s.mem_ready = 1; apply(s, 1);
        s = idle(); repeat (2) apply(s, 1);

        // stall saturation, then reset during MEM_WAIT
        s = idle(); s.id_valid = 1; s.id_src1 = 5; s.exe_dest = 5; s.exe_wb_en = 1;
        repeat (20) apply(s, 1);
        s = idle(); s.mem_req = 1; apply(s, 1);
        s.mem_req = 0; apply(s, 1);
        s.rst = 0; apply(s, 1);
        s = idle(); repeat (2) apply(s, 1);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            s.rst          = ($urandom_range(0, 99) != 0);
            s.id_src1      = pick_reg();
            s.id_src2      = pick_reg();
            s.exe_dest     = pick_reg();
            s.mem_dest     = pick_reg();
            s.id_two_src   = 1'($urandom_range(0, 1));
            s.id_valid     = ($urandom_range(0, 3) != 0);
            s.exe_wb_en    = 1'($urandom_range(0, 1));
            s.exe_mem_r_en = 1'($urandom_range(0, 1));
            s.mem_wb_en    = 1'($urandom_range(0, 1));
            s.mem_req      = ($urandom_range(0, 4) == 0);
            s.mem_ready    = ($urandom_range(0, 5) == 0);
            s.br_taken     = ($urandom_range(0, 5) == 0);
            apply(s, 1);
        end

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
